// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared command, state and mode types for the timer bank
package timer_pkg;

    typedef enum logic [1:0] {
        CMD_NOP           = 2'd0,
        CMD_LOAD_ONESHOT  = 2'd1,
        CMD_LOAD_PERIODIC = 2'd2,
        CMD_STOP          = 2'd3
    } timer_cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_e;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } timer_mode_e;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: run/idle FSM, counter, compare, pulse and sticky flag
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic [1:0]       cmd_i,
    input  logic [CNT_W-1:0] cfg_val_i,
    input  logic             irq_clr_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             pending_o
);

    timer_cmd_e   cmd;
    timer_state_e state_q;
    timer_mode_e  mode_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] compare_q;
    logic             pulse_q;
    logic             pending_q;

    assign cmd = timer_cmd_e'(cmd_i);

    // Channel FSM; an incoming command takes priority over an expiry in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_ONESHOT;
            count_q   <= '0;
            compare_q <= '0;
            pulse_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            pulse_q   <= 1'b0;
            pending_q <= pending_q & ~irq_clr_i;
            case (cmd)
                CMD_LOAD_ONESHOT, CMD_LOAD_PERIODIC: begin
                    count_q   <= '0;
                    compare_q <= cfg_val_i;
                    mode_q    <= (cmd == CMD_LOAD_PERIODIC) ? MODE_PERIODIC : MODE_ONESHOT;
                    state_q   <= ST_RUN;
                end
                CMD_STOP: begin
                    if (state_q == ST_RUN) begin
                        state_q <= ST_IDLE;
                        count_q <= '0;
                    end
                end
                default: begin
                    if (state_q == ST_RUN && tick_i) begin
                        if (count_q >= compare_q) begin
                            // Expiry: set wins over a coincident clear.
                            pulse_q   <= 1'b1;
                            pending_q <= 1'b1;
                            count_q   <= '0;
                            if (mode_q == MODE_ONESHOT) begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign pulse_o   = pulse_q;
    assign busy_o    = (state_q == ST_RUN);
    assign pending_o = pending_q;

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel timer with shared prescaler and aggregated interrupt
module timer_bank
    import timer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_cmd,
    input  logic [CNT_W-1:0]   cfg_val,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic [NUM_CH-1:0]  irq_clr,
    output logic [NUM_CH-1:0]  timer_pulse,
    output logic [NUM_CH-1:0]  timer_busy,
    output logic [NUM_CH-1:0]  irq_pending,
    output logic               irq
);

    logic [PRESC_W-1:0] presc_cnt_q;
    logic [PRESC_W-1:0] presc_cnt_d;
    logic               tick;
    logic [31:0]        cfg_ch_ext;
    logic               cmd_valid;

    // Compare with >= so that lowering presc_div mid-count ticks right away.
    assign tick = (presc_cnt_q >= presc_div);

    // Prescaler next state: wrap to zero on tick, otherwise count up.
    always_comb begin
        presc_cnt_d = presc_cnt_q + 1'b1;
        if (tick) begin
            presc_cnt_d = '0;
        end
    end

    // Free-running prescaler register shared by all channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

    // Commands aimed past the last channel are dropped here.
    assign cfg_ch_ext = 32'(cfg_ch);
    assign cmd_valid  = cfg_we && (cfg_ch_ext < 32'(NUM_CH));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0] ch_cmd;

        assign ch_cmd = (cmd_valid && cfg_ch_ext == 32'(i)) ? cfg_cmd : 2'(CMD_NOP);

        timer_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .tick_i    (tick),
            .cmd_i     (ch_cmd),
            .cfg_val_i (cfg_val),
            .irq_clr_i (irq_clr[i]),
            .pulse_o   (timer_pulse[i]),
            .busy_o    (timer_busy[i]),
            .pending_o (irq_pending[i])
        );
    end

    assign irq = |irq_pending;

endmodule
